// File: rtl/block_luma_sum.sv
// block_luma_sum: 5x5 block luminance sums (/4) over an RGB pixel stream, one sum strobe per completed block.
// Define BLOCK_LUMA_WEIGHTED_EN for weighted RGB luma; otherwise luma is the green channel.
module block_luma_sum #(
    parameter int FRAME_WIDTH     = 1120,
    parameter int BLOCKS_PER_LINE = FRAME_WIDTH / 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic        pix_sol,
    output logic [10:0] sum,
    output logic        sum_valid,
    output logic [7:0]  block_col,
    output logic [7:0]  block_row,
    output logic        new_frame
);
    localparam int XW = $clog2(FRAME_WIDTH + 1);
    localparam int CW = BLOCKS_PER_LINE > 1 ? $clog2(BLOCKS_PER_LINE) : 1;

    typedef enum logic {WAIT_SOF, ACTIVE} stateT;
    stateT state;

    logic [XW-1:0] x, curX;
    logic [2:0]    phase, curPhase, line, curLine;
    logic [7:0]    col, curCol, row, curRow;
    logic          accept;
    logic [7:0]    luma;

    logic          s1Valid, s1First, s1Last;
    logic [7:0]    s1Luma, s1Col, s1Row;
    logic [2:0]    s1Line;

    logic [10:0]   hsum, hNext;
    logic [12:0]   stored, total;
    logic [12:0]   partial [BLOCKS_PER_LINE];
    logic          blockDone;
    logic          unusedBits;

`ifdef BLOCK_LUMA_WEIGHTED_EN
    logic [15:0] weighted;
    assign weighted = 16'd77 * {8'd0, pix_data[23:16]} + 16'd150 * {8'd0, pix_data[15:8]}
                    + 16'd29 * {8'd0, pix_data[7:0]};
    assign luma = weighted[15:8];
    assign unusedBits = ^{weighted[7:0], total[1:0]};
`else
    assign luma = pix_data[15:8];
    assign unusedBits = ^{pix_data[23:16], pix_data[7:0], total[1:0]};
`endif

    // Coordinates of the pixel on the bus, after applying its start flags.
    always_comb begin
        curX     = (pix_sof || pix_sol) ? '0 : x;
        curPhase = (pix_sof || pix_sol) ? 3'd0 : phase;
        curCol   = (pix_sof || pix_sol) ? 8'd0 : col;
        curLine  = pix_sof ? 3'd0 : pix_sol ? (line == 3'd4 ? 3'd0 : line + 3'd1) : line;
        curRow   = pix_sof ? 8'd0 : (pix_sol && line == 3'd4) ? row + 8'd1 : row;
        accept   = pix_valid && (pix_sof || (state == ACTIVE && (pix_sol || x < XW'(FRAME_WIDTH))));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_SOF;
            x         <= '0;
            phase     <= 3'd0;
            col       <= 8'd0;
            line      <= 3'd0;
            row       <= 8'd0;
            s1Valid   <= 1'b0;
            new_frame <= 1'b0;
        end else begin
            new_frame <= pix_valid && pix_sof;
            s1Valid   <= accept;
            if (pix_valid && pix_sof)
                state <= ACTIVE;
            if (accept) begin
                x     <= curX + XW'(1);
                phase <= curPhase == 3'd4 ? 3'd0 : curPhase + 3'd1;
                col   <= curPhase == 3'd4 ? curCol + 8'd1 : curCol;
                line  <= curLine;
                row   <= curRow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1Luma  <= luma;
            s1First <= curPhase == 3'd0;
            s1Last  <= curPhase == 3'd4;
            s1Col   <= curCol;
            s1Line  <= curLine;
            s1Row   <= curRow;
        end
    end

    // A block column's horizontal run restarts on its first pixel, so aborted runs need no clearing.
    always_comb begin
        hNext     = s1First ? {3'd0, s1Luma} : hsum + {3'd0, s1Luma};
        stored    = partial[s1Col[CW-1:0]];
        total     = stored + {2'd0, hNext};
        blockDone = s1Valid && s1Last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsum      <= 11'd0;
            sum       <= 11'd0;
            sum_valid <= 1'b0;
            block_col <= 8'd0;
            block_row <= 8'd0;
        end else begin
            sum_valid <= blockDone && s1Line == 3'd4;
            if (s1Valid)
                hsum <= hNext;
            if (blockDone && s1Line == 3'd4) begin
                sum       <= total[12:2];
                block_col <= s1Col;
                block_row <= s1Row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (blockDone && s1Line < 3'd4)
            partial[s1Col[CW-1:0]] <= s1Line == 3'd0 ? {2'd0, hNext} : total;
    end
endmodule

// File: doc/block_luma_sum.md
BLOCK_LUMA_SUM -- requirements
Module: block_luma_sum

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 1120: active pixels per line; must be a multiple of 5.
REQ-002 SHALL have parameter BLOCKS_PER_LINE, default FRAME_WIDTH/5 (224): number of 5x5 block columns.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-005 SHALL have port pix_data, input, 24: RGB pixel, {R[23:16],G[15:8],B[7:0]}.
REQ-006 SHALL have port pix_valid, input, 1: qualifies pix_data and the start flags.
REQ-007 SHALL have port pix_sof, input, 1: first pixel of frame; valid only with pix_valid.
REQ-008 SHALL have port pix_sol, input, 1: first pixel of line; valid only with pix_valid.
REQ-009 SHALL have port sum, output, 11: block luminance sum divided by 4.
REQ-010 SHALL have port sum_valid, output, 1: one-cycle strobe qualifying sum, block_col and block_row.
REQ-011 SHALL have port block_col, output, 8: block column index of sum.
REQ-012 SHALL have port block_row, output, 8: block row index of sum.
REQ-013 SHALL have port new_frame, output, 1: one-cycle pulse per accepted pix_sof, for the downstream halftone stage.

Function
REQ-014 SHALL have states WAIT_SOF and ACTIVE.
- WAIT_SOF: all pixels ignored.
- Any valid pix_sof enters ACTIVE.
REQ-015 SHALL compute 8-bit luma in stage 1, one cycle after a valid pixel is accepted.
REQ-016 SHALL keep x (0..FRAME_WIDTH-1) and line-in-block (0..4) counters.
- pix_sol sets x=0; pix_sof also clears line-in-block to 0 and block_row to 0.
- pix_sol after x reached FRAME_WIDTH increments line-in-block (4 wraps to 0, block_row+1).
REQ-017 SHALL ignore pixels with x >= FRAME_WIDTH until the next pix_sol or pix_sof.
REQ-018 SHALL accumulate 5 consecutive luma values of one block column into an 11-bit horizontal sum.
REQ-019 SHALL hold one 13-bit partial sum per block column in a BLOCKS_PER_LINE-entry memory.
- Line-in-block 0: store horizontal sum (overwrite, no clearing pass).
- Lines 1-3: add to stored partial.
REQ-020 SHALL, on line-in-block 4, form total = partial + horizontal sum (13 bits, max 6375 at full white).
- Drive sum=total[12:2], block_col and block_row.
- Pulse sum_valid exactly 2 cycles after the 25th pixel of the block was accepted.
REQ-021 SHALL register new_frame high on the cycle after an accepted pix_sof.
REQ-022 SHALL, on pix_sof mid-block or mid-line, discard the in-progress horizontal sum and restart counters.
- No sum_valid is produced for the aborted block.
- Stale memory contents are overwritten per REQ-019.
REQ-023 SHALL, on pix_sol before x reaches FRAME_WIDTH (short line), advance the line counter as normal.
- The unfinished block's horizontal sum is discarded.
- The partial for that column keeps its old value.
REQ-024 SHALL accept one pixel per cycle with no backpressure; idle cycles (pix_valid=0) change no state.
REQ-025 SHALL let block_row wrap from 255 to 0.

Reset
REQ-026 SHALL, on reset, return to WAIT_SOF and drive sum, sum_valid, block_col, block_row and new_frame to 0.
REQ-027 SHALL clear all counters and the pipeline valid bits on reset; memory contents need not be cleared.
REQ-028 SHALL let reset mid-block suppress any pending sum_valid, including one already in the 2-stage pipeline.

Configuration
REQ-029 SHALL use macro BLOCK_LUMA_WEIGHTED_EN to select the luma formula.
- Defined: luma = (77*R + 150*G + 29*B) >> 8, 16-bit intermediate, result 8 bits.
- Undefined: luma = G, with no multipliers synthesized.
- Latency is identical in both builds.

Verification
REQ-030 SHALL cover full-white frame: all pix_data=FFFFFF, FRAME_WIDTH=20, 5 lines.
- Response: 4 sum_valid pulses, each sum=1593, block_col 0..3, block_row 0.
REQ-031 SHALL cover column ramp: pix_data=000000 for x<5, 808080 otherwise, 5 lines.
- Response: col0 sum=0; cols 1..3 sum=800 (weighted build: 25*128>>2).
REQ-032 SHALL cover latency: 25th pixel of block 0 accepted at cycle N.
- Response: sum_valid high at N+2 only; new_frame high at the cycle after pix_sof.
REQ-033 SHALL cover mid-frame restart: pix_sof injected at x=7 of line 3.
- Response: no sum_valid for the old frame; the next 5 full lines give correct sums with block_row=0.
REQ-034 SHALL cover reset at line 4, x=4 (one pixel before block end).
- Response: no sum_valid; outputs 0; pixels ignored until the next pix_sof.
REQ-035 SHALL cover pix_valid gaps: same stimulus as REQ-030 with pix_valid low every other cycle.
- Response: identical sums and indices.
